axi4_stream_pkt_gen: RTL
========================

// Module: axi4_stream_pkt_gen
// PURPOSE
//  AXI4-Stream master (transmitter) that emits one packet per start request.
//  Payload is an incrementing byte pattern from a seed, TLAST on final beat,
//  partial final beat marked via TKEEP/TSTRB. Used as a traffic source for
//  stream slaves and processing modules, in benches and on-chip self-test.
// PARAMETERS
//  N_BYTES    4   bytes per beat; TDATA width = 8*N_BYTES
//  TID_WIDTH  4   width of TID / pkt_id
//  LEN_WIDTH  16  width of pkt_len (bytes); max packet 2^LEN_WIDTH-1 bytes
// PORTS
//  ACLK      in   1            global clock, all logic on rising edge
//  ARESETn   in   1            reset, synchronous, active LOW
//  start     in   1            request a packet; sampled only in IDLE
//  pkt_len   in   LEN_WIDTH    packet length in bytes, latched on accepted start
//  pkt_id    in   TID_WIDTH    TID for packet, latched on accepted start
//  seed      in   8            value of payload byte 0, latched on accepted start
//  busy      out  1            1 while in SEND
//  done      out  1            1-cycle pulse after final handshake
//  TVALID    out  1            stream valid
//  TREADY    in   1            stream ready from slave
//  TDATA     out  8*N_BYTES    payload, byte 0 in bits [7:0]
//  TSTRB     out  N_BYTES      equals TKEEP
//  TKEEP     out  N_BYTES      1 = data byte, 0 = null byte
//  TLAST     out  1            final beat of packet
//  TID       out  TID_WIDTH    latched pkt_id, constant over packet
//  TDEST     out  1            driven 0 (unused)
//  TUSER     out  1            driven 0 (unused)
// BEHAVIOUR
//  - Reset (ARESETn low at rising edge): state IDLE; TVALID, TLAST, busy, done,
//    TDATA, TKEEP, TSTRB, TID all 0. Applies mid-packet: packet abandoned,
//    TVALID low after that edge, no done pulse.
//  - FSM states IDLE, SEND.
//    IDLE: start=1 & pkt_len!=0 -> latch len/id/seed, byte index=0, go SEND;
//      TVALID=1 on the next cycle. start with pkt_len==0: ignored, no done.
//    SEND: TVALID=1, busy=1. Beat held stable (TDATA/TKEEP/TLAST/TID) until
//      TVALID&TREADY. On handshake of non-last beat: byte index += N_BYTES,
//      next beat presented next cycle (no bubble). On handshake of last beat:
//      go IDLE, TVALID=0 and done=1 next cycle.
//  - start while in SEND ignored (not queued). Earliest next start is the
//    done cycle -> exactly one TVALID=0 cycle between back-to-back packets.
//  - Beats = ceil(pkt_len/N_BYTES). Payload byte i (packet-relative) =
//    (seed + i) mod 256, 8-bit wrap.
//  - Last beat: r = pkt_len mod N_BYTES; TKEEP = all ones if r==0, else lower
//    r bits set. Null bytes have TDATA byte = 0. TSTRB = TKEEP always.
//  - Non-last beats: TKEEP all ones, TLAST 0.
//  - Byte index counter LEN_WIDTH bits, no overflow since index < pkt_len.
//  - TVALID never depends combinationally on TREADY. All outputs registered.
// TESTING
//  1. N_BYTES=4, len=8, seed=0x10, TREADY=1 -> beats 0x13121110, 0x17161514;
//     TKEEP=0xF both; TLAST on beat 2 only; done pulse 1 cycle after beat 2.
//  2. len=6, seed=0x00 -> beat1 0x03020100 TKEEP 0xF; beat2 0x00000504,
//     TKEEP=TSTRB=0x3, TLAST=1.
//  3. len=12, TREADY low 3 cycles during beat 1 -> TVALID/TDATA/TLAST/TID
//     stable until handshake; 3 beats total, then done.
//  4. seed=0xFE, len=4 -> single beat 0x0100FFFE, TLAST=1 (byte wrap).
//  5. start with len=0 -> no TVALID, no done; start pulsed during SEND ->
//     ignored, only one packet emitted, TID = id latched at first start.
//  6. ARESETn low mid-packet (beat 2 of 4) -> TVALID/busy 0 after edge, no
//     done; subsequent start emits fresh packet from byte 0 of its seed.

Source files
------------

// File: rtl/axi4_stream_pkt_gen_if.sv
// AXI4-Stream bus bundle with transmitter (master) and receiver (slave) views.
interface axi4_stream_pkt_gen_if #(
    parameter int unsigned N_BYTES   = 4,
    parameter int unsigned TID_WIDTH = 4
) ();
    logic                   TVALID;
    logic                   TREADY;
    logic [8*N_BYTES-1:0]   TDATA;
    logic [N_BYTES-1:0]     TSTRB;
    logic [N_BYTES-1:0]     TKEEP;
    logic                   TLAST;
    logic [TID_WIDTH-1:0]   TID;
    logic                   TDEST;
    logic                   TUSER;

    modport master (
        output TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER,
        input  TREADY
    );

    modport slave (
        input  TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER,
        output TREADY
    );
endinterface

// File: rtl/axi4_stream_pkt_gen.sv
// AXI4-Stream packet source: one packet per accepted start, incrementing byte payload from a seed,
// partial last beat flagged through TKEEP/TSTRB. All stream outputs come straight from flops.
module axi4_stream_pkt_gen #(
    parameter int unsigned N_BYTES   = 4,
    parameter int unsigned TID_WIDTH = 4,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] pkt_len_i,
    input  logic [TID_WIDTH-1:0] pkt_id_i,
    input  logic [7:0]           seed_i,
    output logic                 busy_o,
    output logic                 done_o,
    axi4_stream_pkt_gen_if.master axis
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    typedef struct packed {
        logic [8*N_BYTES-1:0] data;
        logic [N_BYTES-1:0]   keep;
        logic                 last;
    } beat_t;

    // Builds the beat starting at packet byte idx; bytes at or past len are null and zeroed.
    function automatic beat_t calc_beat(input logic [LEN_WIDTH-1:0] idx,
                                        input logic [LEN_WIDTH-1:0] len,
                                        input logic [7:0]           seed);
        beat_t                b;
        logic [LEN_WIDTH-1:0] rem;
        b   = '0;
        rem = len - idx;
        for (int unsigned i = 0; i < N_BYTES; i++) begin
            if (LEN_WIDTH'(i) < rem) begin
                b.keep[i]       = 1'b1;
                b.data[8*i +: 8] = seed + idx[7:0] + 8'(i);
            end
        end
        b.last = (rem <= LEN_WIDTH'(N_BYTES));
        return b;
    endfunction

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] idx_q, idx_d;
    logic [7:0]           seed_q, seed_d;
    logic [TID_WIDTH-1:0] tid_q, tid_d;
    logic                 tvalid_q, tvalid_d;
    logic [8*N_BYTES-1:0] tdata_q, tdata_d;
    logic [N_BYTES-1:0]   tkeep_q, tkeep_d;
    logic                 tlast_q, tlast_d;
    logic                 done_q, done_d;
    beat_t                beat;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        seed_d   = seed_q;
        tid_d    = tid_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;
        beat     = '0;

        unique case (state_q)
            StIdle: begin
                if (start_i && (pkt_len_i != '0)) begin
                    beat     = calc_beat('0, pkt_len_i, seed_i);
                    state_d  = StSend;
                    len_d    = pkt_len_i;
                    seed_d   = seed_i;
                    tid_d    = pkt_id_i;
                    idx_d    = '0;
                    tvalid_d = 1'b1;
                    tdata_d  = beat.data;
                    tkeep_d  = beat.keep;
                    tlast_d  = beat.last;
                end
            end
            StSend: begin
                if (axis.TREADY) begin
                    if (tlast_q) begin
                        state_d  = StIdle;
                        tvalid_d = 1'b0;
                        tdata_d  = '0;
                        tkeep_d  = '0;
                        tlast_d  = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q + LEN_WIDTH'(N_BYTES);
                        beat    = calc_beat(idx_d, len_q, seed_q);
                        tdata_d = beat.data;
                        tkeep_d = beat.keep;
                        tlast_d = beat.last;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q  <= StIdle;
            len_q    <= '0;
            idx_q    <= '0;
            seed_q   <= '0;
            tid_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            seed_q   <= seed_d;
            tid_q    <= tid_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
        end
    end

    assign busy_o      = (state_q == StSend);
    assign done_o      = done_q;
    assign axis.TVALID = tvalid_q;
    assign axis.TDATA  = tdata_q;
    assign axis.TKEEP  = tkeep_q;
    assign axis.TSTRB  = tkeep_q;
    assign axis.TLAST  = tlast_q;
    assign axis.TID    = tid_q;
    assign axis.TDEST  = 1'b0;
    assign axis.TUSER  = 1'b0;

endmodule
